// File: rtl/operand_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_issue_pkg
//  Description : Shared configuration for the operand issue stage: default
//                datapath/control widths, forward-select encoding and a
//                saturating counter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package operand_issue_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int CTRL_W_DEFAULT = 16;

    // Source selected for a resolved operand.
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF   = 2'd0;
    localparam fwd_sel_t FWD_EX   = 2'd1;
    localparam fwd_sel_t FWD_WB   = 2'd2;
    localparam fwd_sel_t FWD_ZERO = 2'd3;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage : operand_issue_pkg
`default_nettype wire

// File: rtl/operand_issue_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : operand_bypass
//  Description : Combinational resolution of one source operand. Picks x0,
//                the EX result, the same-cycle WB write or the register file
//                read data, and flags a load-use hazard when the operand
//                depends on an EX result that is not available yet.
//  Ports       : i_addr / i_use_en     - operand index and read flag
//                i_rf_data             - register file read data
//                i_ex_fwd_*            - EX stage destination/result/pending
//                i_wb_*                - register file write port
//                o_value               - resolved operand
//                o_hazard              - operand must wait for a pending load
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass
    import operand_issue_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [4:0]      i_addr,
    input  logic            i_use_en,
    input  logic [XLEN-1:0] i_rf_data,
    input  logic            i_ex_fwd_en,
    input  logic [4:0]      i_ex_fwd_addr,
    input  logic [XLEN-1:0] i_ex_fwd_data,
    input  logic            i_ex_fwd_pending,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_value,
    output logic            o_hazard
);

    logic     w_addr_nz;
    logic     w_ex_hit;
    logic     w_wb_hit;
    fwd_sel_t w_sel;

    assign w_addr_nz = (i_addr != 5'd0);
    assign w_ex_hit  = i_ex_fwd_en && (i_ex_fwd_addr == i_addr);
    assign w_wb_hit  = i_wb_en && (i_wb_addr == i_addr);

    // A pending EX match must not select EX data; it falls through to WB/RF
    // and the hazard output holds the instruction back when the operand is used.
    always_comb begin
        w_sel = FWD_RF;
        if (!w_addr_nz) begin
            w_sel = FWD_ZERO;
        end else if (w_ex_hit && !i_ex_fwd_pending) begin
            w_sel = FWD_EX;
        end else if (w_wb_hit) begin
            w_sel = FWD_WB;
        end
    end

    always_comb begin
        o_value = i_rf_data;
        case (w_sel)
            FWD_EX:   o_value = i_ex_fwd_data;
            FWD_WB:   o_value = i_wb_data;
            FWD_ZERO: o_value = '0;
            default:  o_value = i_rf_data;
        endcase
    end

    // Unused operands and x0 never wait on a load.
    assign o_hazard = i_use_en && w_addr_nz && w_ex_hit && i_ex_fwd_pending;

endmodule : operand_bypass
`default_nettype wire

// File: rtl/operand_issue.sv
`default_nettype none
// ============================================================================
//  Module      : operand_issue
//  Description : Decode-to-execute issue stage. Drives the register file read
//                addresses, resolves both operands through the EX/WB bypass
//                network, stalls decode on load-use hazards and registers one
//                operand bundle per cycle toward EX with valid/ready and
//                flush. Counts hazard-stall cycles (saturating).
//  Ports       : id_*        - decoded instruction from decode (valid/ready)
//                rf_*        - register file combinational read ports
//                ex_fwd_*    - EX stage destination/result/pending
//                wb_*        - register file write port (same cycle)
//                flush       - kill issued and accepting instruction
//                ex_*        - registered operand bundle toward EX
//                stall_count - saturating hazard-stall cycle count
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [4:0]        id_rd_addr,
    input  logic              id_rd_en,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,

    output logic [4:0]        rf_rs1_addr,
    output logic [4:0]        rf_rs2_addr,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data,

    input  logic              ex_fwd_en,
    input  logic [4:0]        ex_fwd_addr,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              ex_fwd_pending,

    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [XLEN-1:0]   wb_data,

    input  logic              flush,

    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_rd_en,
    output logic [CTRL_W-1:0] ex_ctrl,

    output logic [31:0]       stall_count
);

    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic              w_rs1_hazard;
    logic              w_rs2_hazard;
    logic              w_hazard;
    logic              w_slot_free;
    logic              w_accept;
    logic              w_stall_evt;

    logic              r_ex_valid;
    logic [XLEN-1:0]   r_ex_pc;
    logic [XLEN-1:0]   r_ex_imm;
    logic [XLEN-1:0]   r_ex_rs1_val;
    logic [XLEN-1:0]   r_ex_rs2_val;
    logic [4:0]        r_ex_rd_addr;
    logic              r_ex_rd_en;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [31:0]       r_stall_count;

    // Register file is read directly with the decode indices.
    assign rf_rs1_addr = id_rs1_addr;
    assign rf_rs2_addr = id_rs2_addr;

    operand_bypass #(
        .XLEN (XLEN)
    ) u_bypass_rs1 (
        .i_addr           (id_rs1_addr),
        .i_use_en         (id_uses_rs1),
        .i_rf_data        (rf_rs1_data),
        .i_ex_fwd_en      (ex_fwd_en),
        .i_ex_fwd_addr    (ex_fwd_addr),
        .i_ex_fwd_data    (ex_fwd_data),
        .i_ex_fwd_pending (ex_fwd_pending),
        .i_wb_en          (wb_en),
        .i_wb_addr        (wb_addr),
        .i_wb_data        (wb_data),
        .o_value          (w_rs1_val),
        .o_hazard         (w_rs1_hazard)
    );

    operand_bypass #(
        .XLEN (XLEN)
    ) u_bypass_rs2 (
        .i_addr           (id_rs2_addr),
        .i_use_en         (id_uses_rs2),
        .i_rf_data        (rf_rs2_data),
        .i_ex_fwd_en      (ex_fwd_en),
        .i_ex_fwd_addr    (ex_fwd_addr),
        .i_ex_fwd_data    (ex_fwd_data),
        .i_ex_fwd_pending (ex_fwd_pending),
        .i_wb_en          (wb_en),
        .i_wb_addr        (wb_addr),
        .i_wb_data        (wb_data),
        .o_value          (w_rs2_val),
        .o_hazard         (w_rs2_hazard)
    );

    assign w_hazard    = w_rs1_hazard || w_rs2_hazard;
    assign w_slot_free = !r_ex_valid || ex_ready;
    assign id_ready    = w_slot_free && !w_hazard && !flush;
    assign w_accept    = id_valid && id_ready;
    // Only cycles lost purely to the hazard are counted: a full slot or a
    // flush would have blocked the instruction anyway.
    assign w_stall_evt = id_valid && w_slot_free && w_hazard && !flush;

    // Output slot. Flush wins over accept; the payload is simply left as is
    // on flush, which keeps it at a defined value without extra muxing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_pc      <= '0;
            r_ex_imm     <= '0;
            r_ex_rs1_val <= '0;
            r_ex_rs2_val <= '0;
            r_ex_rd_addr <= '0;
            r_ex_rd_en   <= 1'b0;
            r_ex_ctrl    <= '0;
        end else begin
            if (flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_accept) begin
                r_ex_valid   <= 1'b1;
                r_ex_pc      <= id_pc;
                r_ex_imm     <= id_imm;
                r_ex_rs1_val <= w_rs1_val;
                r_ex_rs2_val <= w_rs2_val;
                r_ex_rd_addr <= id_rd_addr;
                r_ex_rd_en   <= id_rd_en;
                r_ex_ctrl    <= id_ctrl;
            end else if (ex_ready) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall_evt) begin
            r_stall_count <= sat_inc32(r_stall_count);
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_ex_pc;
    assign ex_imm      = r_ex_imm;
    assign ex_rs1_val  = r_ex_rs1_val;
    assign ex_rs2_val  = r_ex_rs2_val;
    assign ex_rd_addr  = r_ex_rd_addr;
    assign ex_rd_en    = r_ex_rd_en;
    assign ex_ctrl     = r_ex_ctrl;
    assign stall_count = r_stall_count;

endmodule : operand_issue
`default_nettype wire

// File: tb/tb_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_issue
//  Description : Self-checking bench for operand_issue. Accepted instructions
//                push their expected bundle into a scoreboard queue; the
//                bundle is compared while held in EX and popped when consumed
//                or flushed. Directed scenarios are followed by a random run
//                and a mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_issue;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1_addr;
    logic [4:0]        id_rs2_addr;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [4:0]        id_rd_addr;
    logic              id_rd_en;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        rf_rs1_addr;
    logic [4:0]        rf_rs2_addr;
    logic [XLEN-1:0]   rf_rs1_data;
    logic [XLEN-1:0]   rf_rs2_data;
    logic              ex_fwd_en;
    logic [4:0]        ex_fwd_addr;
    logic [XLEN-1:0]   ex_fwd_data;
    logic              ex_fwd_pending;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_rs1_val;
    logic [XLEN-1:0]   ex_rs2_val;
    logic [4:0]        ex_rd_addr;
    logic              ex_rd_en;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       stall_count;

    logic [XLEN-1:0]   rf_mem [32];

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [4:0]        rd;
        logic              rd_en;
        logic [CTRL_W-1:0] ctrl;
    } bundle_t;

    bundle_t     sb_q [$];
    int          vec_cnt  = 0;
    int          miscmp   = 0;
    logic [31:0] exp_stall = '0;

    always #5 clk = ~clk;

    // Register file model: combinational read on the DUT's read addresses.
    assign rf_rs1_data = rf_mem[rf_rs1_addr];
    assign rf_rs2_data = rf_mem[rf_rs2_addr];

    operand_issue #(
        .XLEN   (XLEN),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_rd_addr     (id_rd_addr),
        .id_rd_en       (id_rd_en),
        .id_imm         (id_imm),
        .id_ctrl        (id_ctrl),
        .rf_rs1_addr    (rf_rs1_addr),
        .rf_rs2_addr    (rf_rs2_addr),
        .rf_rs1_data    (rf_rs1_data),
        .rf_rs2_data    (rf_rs2_data),
        .ex_fwd_en      (ex_fwd_en),
        .ex_fwd_addr    (ex_fwd_addr),
        .ex_fwd_data    (ex_fwd_data),
        .ex_fwd_pending (ex_fwd_pending),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1_val     (ex_rs1_val),
        .ex_rs2_val     (ex_rs2_val),
        .ex_rd_addr     (ex_rd_addr),
        .ex_rd_en       (ex_rd_en),
        .ex_ctrl        (ex_ctrl),
        .stall_count    (stall_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference operand resolution from the current bench-driven inputs.
    function automatic logic [XLEN-1:0] resolve(input logic [4:0] a);
        if (a == 5'd0)                                      return '0;
        if (ex_fwd_en && ex_fwd_addr == a && !ex_fwd_pending) return ex_fwd_data;
        if (wb_en && wb_addr == a)                          return wb_data;
        return rf_mem[a];
    endfunction

    task automatic set_id(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rd_en, input logic [XLEN-1:0] imm, input logic [CTRL_W-1:0] ctrl);
        id_pc = pc; id_rs1_addr = rs1; id_uses_rs1 = u1; id_rs2_addr = rs2; id_uses_rs2 = u2;
        id_rd_addr = rd; id_rd_en = rd_en; id_imm = imm; id_ctrl = ctrl;
    endtask

    task automatic set_fwd(input logic en, input logic [4:0] a, input logic [XLEN-1:0] d, input logic pend);
        ex_fwd_en = en; ex_fwd_addr = a; ex_fwd_data = d; ex_fwd_pending = pend;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [XLEN-1:0] d);
        wb_en = en; wb_addr = a; wb_data = d;
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    // Checks the current state, updates the scoreboard, advances one cycle.
    task automatic step();
        bundle_t b;
        bundle_t nb;
        logic    had_valid;
        logic    hz;
        logic    slot_m;
        logic    rdy_m;
        #3;
        had_valid = (sb_q.size() != 0);
        chk("ex_valid", ex_valid, had_valid);
        chk("stall_count", stall_count, exp_stall);
        chk("rf_rs1_addr", rf_rs1_addr, id_rs1_addr);
        chk("rf_rs2_addr", rf_rs2_addr, id_rs2_addr);
        if (had_valid && !flush) begin
            b = sb_q[0];
            chk("ex_pc", ex_pc, b.pc);
            chk("ex_imm", ex_imm, b.imm);
            chk("ex_rs1_val", ex_rs1_val, b.rs1);
            chk("ex_rs2_val", ex_rs2_val, b.rs2);
            chk("ex_rd_addr", ex_rd_addr, b.rd);
            chk("ex_rd_en", ex_rd_en, b.rd_en);
            chk("ex_ctrl", ex_ctrl, b.ctrl);
        end
        if (had_valid && (flush || ex_ready)) void'(sb_q.pop_front());

        hz = (id_uses_rs1 && id_rs1_addr != 5'd0 && ex_fwd_en && ex_fwd_pending && ex_fwd_addr == id_rs1_addr) ||
             (id_uses_rs2 && id_rs2_addr != 5'd0 && ex_fwd_en && ex_fwd_pending && ex_fwd_addr == id_rs2_addr);
        slot_m = !had_valid || ex_ready;
        rdy_m  = slot_m && !hz && !flush;
        chk("id_ready", id_ready, rdy_m);

        if (id_valid && slot_m && hz && !flush && exp_stall != 32'hFFFF_FFFF) exp_stall++;
        if (id_valid && rdy_m) begin
            nb.pc    = id_pc;
            nb.imm   = id_imm;
            nb.rs1   = resolve(id_rs1_addr);
            nb.rs2   = resolve(id_rs2_addr);
            nb.rd    = id_rd_addr;
            nb.rd_en = id_rd_en;
            nb.ctrl  = id_ctrl;
            sb_q.push_back(nb);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; ex_ready = 1'b0; flush = 1'b0;
        set_id('0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, '0);
        set_fwd(1'b0, 5'd0, '0, 1'b0);
        set_wb(1'b0, 5'd0, '0);
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 32'hDEAD_BEEF;   // x0 must never be read through
        rf_mem[5] = 32'h0000_0011;

        #1;
        chk("reset_ex_valid", ex_valid, 1'b0);
        chk("reset_stall", stall_count, 32'd0);
        chk("reset_ex_pc", ex_pc, 32'd0);
        chk("reset_ex_rs1", ex_rs1_val, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Plain accept of x5 with no forwarding; ex_valid pulses one cycle.
        ex_ready = 1'b1;
        set_id(32'h100, 5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 32'h4, 16'h0001);
        id_valid = 1'b1; step();
        id_valid = 1'b0; step();
        step();

        // EX beats WB; WB when EX disabled; x0 always zero.
        set_id(32'h200, 5'd7, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 32'h8, 16'h0002);
        set_fwd(1'b1, 5'd7, 32'hAA, 1'b0);
        set_wb(1'b1, 5'd7, 32'hBB);
        id_valid = 1'b1; step();
        id_pc = 32'h204; ex_fwd_en = 1'b0; step();
        id_pc = 32'h208; id_rs1_addr = 5'd0; set_fwd(1'b1, 5'd0, 32'h55, 1'b0); step();
        id_valid = 1'b0; set_fwd(1'b0, 5'd0, '0, 1'b0); set_wb(1'b0, 5'd0, '0); step();

        // Load-use on rs2 for two cycles, then the load data arrives.
        set_id(32'h300, 5'd0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 32'hC, 16'h0003);
        set_fwd(1'b1, 5'd3, 32'h0, 1'b1);
        id_valid = 1'b1; step(); step();
        set_fwd(1'b1, 5'd3, 32'h42, 1'b0); step();
        id_valid = 1'b0; ex_fwd_en = 1'b0; step();
        chk("stall_after_loaduse", stall_count, 32'd2);

        // Backpressure: bundle held three cycles, next loads when ready rises.
        ex_ready = 1'b0;
        set_id(32'h400, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 32'h10, 16'h0004);
        id_valid = 1'b1; step();
        set_id(32'h404, 5'd9, 1'b1, 5'd10, 1'b1, 5'd11, 1'b0, 32'h14, 16'h0005);
        step(); step(); step();
        ex_ready = 1'b1; step();
        id_valid = 1'b0; step();
        step();

        // Flush with a held bundle, a hazard and a valid instruction.
        ex_ready = 1'b0;
        set_id(32'h500, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 32'h18, 16'h0006);
        id_valid = 1'b1; step();
        set_id(32'h504, 5'd0, 1'b0, 5'd3, 1'b1, 5'd14, 1'b1, 32'h1C, 16'h0007);
        set_fwd(1'b1, 5'd3, 32'h0, 1'b1);
        ex_ready = 1'b1; flush = 1'b1; step();
        flush = 1'b0; id_valid = 1'b0; set_fwd(1'b0, 5'd0, '0, 1'b0); step();
        chk("stall_after_flush", stall_count, 32'd2);

        // Random traffic over a small register window to provoke matches.
        for (int n = 0; n < 80; n++) begin
            set_id($urandom, 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), 5'($urandom), 1'($urandom), $urandom, 16'($urandom));
            set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0));
            set_wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            id_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            step();
        end

        // Mid-cycle reset while a bundle is held: outputs clear before any edge.
        flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0;
        set_fwd(1'b0, 5'd0, '0, 1'b0); set_wb(1'b0, 5'd0, '0);
        step();
        ex_ready = 1'b0;
        set_id(32'h600, 5'd5, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 32'h20, 16'h0008);
        id_valid = 1'b1; step();
        chk("pre_reset_ex_valid", ex_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_ex_valid", ex_valid, 1'b0);
        chk("async_reset_stall", stall_count, 32'd0);
        chk("async_reset_ex_pc", ex_pc, 32'd0);
        sb_q.delete();
        exp_stall = '0;
        id_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule : tb_operand_issue
`default_nettype wire

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Decode-to-execute issue stage that consumes the register file's combinational read ports.
- Drives rs1/rs2 read addresses to the register file and bypasses in-flight EX and WB results.
- Detects load-use hazards and stalls decode on them.
- Registers one fully resolved operand bundle per cycle toward EX, with a valid/ready handshake and flush support.

Parameters:
- XLEN, 32, datapath width; matches the core-wide config value.
- CTRL_W, 16, width of the opaque decoded control bundle passed to EX.

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-high
id_valid  input  1  decode holds a valid instruction
id_ready  output  1  issue accepts the instruction this cycle
id_pc  input  XLEN  instruction PC
id_rs1_addr  input  5  source 1 index
id_rs2_addr  input  5  source 2 index
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_rd_addr  input  5  destination index
id_rd_en  input  1  instruction writes rd
id_imm  input  XLEN  decoded immediate
id_ctrl  input  CTRL_W  decoded control bundle
rf_rs1_addr  output  5  register file read address 1; equals id_rs1_addr, combinational
rf_rs2_addr  output  5  register file read address 2; equals id_rs2_addr, combinational
rf_rs1_data  input  XLEN  register file read data 1
rf_rs2_data  input  XLEN  register file read data 2
ex_fwd_en  input  1  instruction in EX will write rd
ex_fwd_addr  input  5  EX destination index
ex_fwd_data  input  XLEN  EX result
ex_fwd_pending  input  1  EX result not yet available (load)
wb_en  input  1  register file write enable, same cycle
wb_addr  input  5  register file write index
wb_data  input  XLEN  register file write data
flush  input  1  kill the issued and the accepting instruction
ex_valid  output  1  output bundle valid
ex_ready  input  1  EX consumes the bundle
ex_pc, ex_imm  output  XLEN  registered copies of the accepted inputs
ex_rs1_val, ex_rs2_val  output  XLEN  resolved operands
ex_rd_addr  output  5  registered destination index
ex_rd_en  output  1  registered write enable
ex_ctrl  output  CTRL_W  registered control bundle
stall_count  output  32  saturating count of hazard-stall cycles

Behaviour:
- Reset: clk and rst are the only clock/reset; rst is asynchronous, active-high. While rst is high, every registered output is 0: ex_valid, all payload fields, and stall_count.
- Operand resolution, evaluated per operand, highest priority first:
  1. Index 0 resolves to 0.
  2. ex_fwd_en, ex_fwd_addr matches, and not pending: ex_fwd_data.
  3. wb_en and wb_addr matches: wb_data. This covers the register file's write-next-edge timing.
  4. Otherwise the rf data.
- Hazard: raised when (id_uses_rs1 and rs1≠0 and matches ex_fwd_addr) or (id_uses_rs2 and rs2≠0 and matches ex_fwd_addr), with ex_fwd_en and ex_fwd_pending both high. An unused operand never causes a hazard.
- Output register slot:
  - slot_free = !ex_valid || ex_ready.
  - id_ready = slot_free && !hazard && !flush.
  - Accept (id_valid && id_ready): the next edge loads the payload and sets ex_valid=1. Latency is 1 cycle from accept to ex_valid.
  - No accept and ex_ready high: ex_valid clears.
  - ex_valid && !ex_ready: the payload holds stable.
- Flush has top priority. On the next edge ex_valid=0, nothing is accepted that cycle, and payload contents are don't-care but must not be X.
- stall_count increments each cycle with id_valid && slot_free && hazard && !flush. It saturates at 0xFFFFFFFF.
- An asserted reset in mid-operation drops the held bundle. No instruction reappears after reset.

Decomposition:
- Shared package/config: XLEN and CTRL_W defaults; forward-select constants FWD_RF=2'd0, FWD_EX=2'd1, FWD_WB=2'd2, FWD_ZERO=2'd3.
- Sub-module operand_bypass: combinational; takes addr, use flag, rf data, and the EX/WB forward inputs; outputs the value and the hazard bit. Instantiated twice.

Test Plan:
1. Reset with rst high mid-cycle, with ex_valid=1 held -> ex_valid=0 and stall_count=0 immediately, before any clock edge.
2. Accept x5 (rf=0x11) with no forwarding; ex_ready=1 -> ex_rs1_val=0x11 one cycle later, ex_valid pulses for one cycle.
3. rs1=x7 with ex_fwd x7=0xAA and wb x7=0xBB -> 0xAA (EX wins). Same with ex_fwd_en=0 -> 0xBB. rs1=x0 with ex_fwd x0 -> 0.
4. Load-use: rs2=x3 with ex_fwd x3 pending for 2 cycles -> id_ready=0 for 2 cycles, stall_count=2. Pending then drops with data 0x42 -> accepted, ex_rs2_val=0x42.
5. Backpressure: ex_valid=1, ex_ready=0 for 3 cycles with id_valid high -> payload unchanged, id_ready=0. ex_ready then rises -> the next instruction loads on that edge.
6. flush asserted together with id_valid and ex_valid -> ex_valid=0 next cycle, the instruction is not captured, and stall_count is unchanged.
